wb_interconnect: RTL and testbench

- Parametrised single-master to N-slave Wishbone (classic) interconnect. Generalises the fixed LED/VGA/RAM strobe decoder: per-slave base/mask address map, registered strobe and response, decode-miss and slave-error reporting.
- Sits between the cpu data-memory port and the peripheral slaves (ram_wishbone, led_wishbone, vga_wishbone).
- One outstanding transaction at a time.

---
 rtl/wb_interconnect.sv | 186 ++++++++++++++++++
 tb/tb_wb_interconnect.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_interconnect.sv
// Single-master to N-slave Wishbone classic interconnect with base/mask decode,
// registered strobes and responses. Define WBIC_TIMEOUT_EN to add a response timeout.
module wb_interconnect #(
  parameter int unsigned NUM_SLAVES     = 3,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'hFFFF4000, 32'hFFFF0000, 32'h00000000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK =
    {32'hFFFFC000, 32'hFFFFFFFF, 32'hFFFF0000},
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                             I_clk,
  input  logic                             I_rst,
  input  logic                             M_CYC_I,
  input  logic                             M_STB_I,
  input  logic                             M_WE_I,
  input  logic [ADDR_WIDTH-1:0]            M_ADR_I,
  input  logic [DATA_WIDTH-1:0]            M_DAT_I,
  input  logic [DATA_WIDTH/8-1:0]          M_SEL_I,
  output logic [DATA_WIDTH-1:0]            M_DAT_O,
  output logic                             M_ACK_O,
  output logic                             M_ERR_O,
  output logic [NUM_SLAVES-1:0]            S_STB_O,
  output logic                             S_WE_O,
  output logic [ADDR_WIDTH-1:0]            S_ADR_O,
  output logic [DATA_WIDTH-1:0]            S_DAT_O,
  output logic [DATA_WIDTH/8-1:0]          S_SEL_O,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] S_DAT_I,
  input  logic [NUM_SLAVES-1:0]            S_ACK_I,
  input  logic [NUM_SLAVES-1:0]            S_ERR_I
);

  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IDX_WIDTH = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

  state_t                  state, state_d;
  logic [IDX_WIDTH-1:0]    idx_q, idx_d;
  logic [NUM_SLAVES-1:0]   stb_d;
  logic                    we_d;
  logic [ADDR_WIDTH-1:0]   adr_d;
  logic [DATA_WIDTH-1:0]   dat_d;
  logic [SEL_WIDTH-1:0]    sel_d;
  logic [DATA_WIDTH-1:0]   mdat_d;
  logic                    ack_d;
  logic                    err_d;

  logic                    hit;
  logic [IDX_WIDTH-1:0]    hit_idx;
  logic                    slv_ack;
  logic                    slv_err;
  logic [DATA_WIDTH-1:0]   slv_dat;

`ifdef WBIC_TIMEOUT_EN
  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
`endif

  // Address decode; scanning downwards leaves the lowest matching index.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
      if ((M_ADR_I & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          (SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hit     = 1'b1;
        hit_idx = IDX_WIDTH'(i);
      end
    end
  end

  // Only the addressed slave's response is visible.
  always_comb begin
    slv_ack = S_ACK_I[idx_q];
    slv_err = S_ERR_I[idx_q];
    slv_dat = S_DAT_I[32'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    state_d = state;
    idx_d   = idx_q;
    stb_d   = S_STB_O;
    we_d    = S_WE_O;
    adr_d   = S_ADR_O;
    dat_d   = S_DAT_O;
    sel_d   = S_SEL_O;
    mdat_d  = M_DAT_O;
    ack_d   = 1'b0;
    err_d   = 1'b0;
`ifdef WBIC_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state)
      IDLE: begin
        if (M_CYC_I && M_STB_I) begin
          we_d  = M_WE_I;
          adr_d = M_ADR_I;
          dat_d = M_DAT_I;
          sel_d = M_SEL_I;
          if (hit) begin
            state_d        = ACTIVE;
            idx_d          = hit_idx;
            stb_d          = '0;
            stb_d[hit_idx] = 1'b1;
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
          end
        end
      end
      ACTIVE: begin
`ifdef WBIC_TIMEOUT_EN
        cnt_d = cnt_q + CNT_WIDTH'(1);
`endif
        if (!M_CYC_I) begin
          state_d = IDLE;
          stb_d   = '0;
`ifdef WBIC_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (slv_err) begin
          state_d = RESP;
          stb_d   = '0;
          err_d   = 1'b1;
`ifdef WBIC_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (slv_ack) begin
          state_d = RESP;
          stb_d   = '0;
          ack_d   = 1'b1;
          if (!S_WE_O) mdat_d = slv_dat;
`ifdef WBIC_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
`ifdef WBIC_TIMEOUT_EN
        else if (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          state_d = RESP;
          stb_d   = '0;
          err_d   = 1'b1;
          cnt_d   = '0;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      state   <= IDLE;
      idx_q   <= '0;
      S_STB_O <= '0;
      S_WE_O  <= 1'b0;
      S_ADR_O <= '0;
      S_DAT_O <= '0;
      S_SEL_O <= '0;
      M_DAT_O <= '0;
      M_ACK_O <= 1'b0;
      M_ERR_O <= 1'b0;
    end else begin
      state   <= state_d;
      idx_q   <= idx_d;
      S_STB_O <= stb_d;
      S_WE_O  <= we_d;
      S_ADR_O <= adr_d;
      S_DAT_O <= dat_d;
      S_SEL_O <= sel_d;
      M_DAT_O <= mdat_d;
      M_ACK_O <= ack_d;
      M_ERR_O <= err_d;
    end
  end

`ifdef WBIC_TIMEOUT_EN
  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_wb_interconnect.sv
// Scoreboard bench for wb_interconnect: stimulus queues expected master responses,
// a negedge monitor pops and compares them whenever ACK or ERR is presented.
module tb_wb_interconnect;

  logic        I_clk = 1'b0;
  logic        I_rst;
  logic        M_CYC_I, M_STB_I, M_WE_I;
  logic [31:0] M_ADR_I, M_DAT_I;
  logic [3:0]  M_SEL_I;
  logic [31:0] M_DAT_O;
  logic        M_ACK_O, M_ERR_O;
  logic [2:0]  S_STB_O;
  logic        S_WE_O;
  logic [31:0] S_ADR_O, S_DAT_O;
  logic [3:0]  S_SEL_O;
  logic [95:0] S_DAT_I;
  logic [2:0]  S_ACK_I, S_ERR_I;

  typedef struct packed {
    logic        ack;
    logic        err;
    logic [31:0] dat;
  } resp_t;

  resp_t exp_q[$];
  resp_t mon_e;
  int    applied = 0;
  int    miscompares = 0;
  int    hi_cnt;

  wb_interconnect #(.TIMEOUT_CYCLES(8)) dut (
    .I_clk(I_clk), .I_rst(I_rst),
    .M_CYC_I(M_CYC_I), .M_STB_I(M_STB_I), .M_WE_I(M_WE_I),
    .M_ADR_I(M_ADR_I), .M_DAT_I(M_DAT_I), .M_SEL_I(M_SEL_I),
    .M_DAT_O(M_DAT_O), .M_ACK_O(M_ACK_O), .M_ERR_O(M_ERR_O),
    .S_STB_O(S_STB_O), .S_WE_O(S_WE_O), .S_ADR_O(S_ADR_O),
    .S_DAT_O(S_DAT_O), .S_SEL_O(S_SEL_O),
    .S_DAT_I(S_DAT_I), .S_ACK_I(S_ACK_I), .S_ERR_I(S_ERR_I)
  );

  always #5 I_clk = ~I_clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Response monitor: every ACK/ERR cycle must match the next queued expectation.
  always @(negedge I_clk) begin
    if (I_rst === 1'b1 && (M_ACK_O === 1'b1 || M_ERR_O === 1'b1)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 128'({M_ACK_O, M_ERR_O}), 128'(2'b00));
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp", 128'({M_ACK_O, M_ERR_O, M_DAT_O}), 128'(mon_e));
      end
    end
  end

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  task automatic request(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
    M_CYC_I = 1'b1; M_STB_I = 1'b1; M_WE_I = we;
    M_ADR_I = adr;  M_DAT_I = dat;  M_SEL_I = sel;
    tick();
    M_STB_I = 1'b0;
  endtask

  task automatic idle_bus();
    M_CYC_I = 1'b0; M_STB_I = 1'b0; M_WE_I = 1'b0;
    S_ACK_I = '0;   S_ERR_I = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    I_rst = 1'b0;
    idle_bus();
    M_ADR_I = '0; M_DAT_I = '0; M_SEL_I = '0; S_DAT_I = '0;
    #2;
    chk("reset_outputs", 128'({M_DAT_O, M_ACK_O, M_ERR_O, S_STB_O, S_WE_O, S_ADR_O, S_DAT_O, S_SEL_O}), 128'(0));
    tick(); tick();
    I_rst = 1'b1;
    tick();

    // Read hit on slave 0, ack in first strobed cycle.
    S_DAT_I[31:0] = 32'hDEADBEEF;
    exp_q.push_back('{ack: 1'b1, err: 1'b0, dat: 32'hDEADBEEF});
    request(1'b0, 32'h0000_0010, 32'h0, 4'hF);
    chk("read_stb", 128'(S_STB_O), 128'(3'b001));
    S_ACK_I = 3'b001;
    tick();
    S_ACK_I = '0;
    chk("read_stb_clear", 128'(S_STB_O), 128'(3'b000));
    chk("read_ack_latency", 128'({M_ACK_O, M_ERR_O, M_DAT_O}), 128'({2'b10, 32'hDEADBEEF}));
    tick();
    M_CYC_I = 1'b0;
    tick();

    // Write hit on slave 1 with three wait cycles.
    exp_q.push_back('{ack: 1'b1, err: 1'b0, dat: 32'hDEADBEEF});
    S_DAT_I[63:32] = 32'h1111_2222;
    request(1'b1, 32'hFFFF_0000, 32'h0000_A5A5, 4'hF);
    chk("write_bus", 128'({S_WE_O, S_ADR_O, S_DAT_O, S_SEL_O}), 128'({1'b1, 32'hFFFF_0000, 32'h0000_A5A5, 4'hF}));
    hi_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (S_STB_O == 3'b010) hi_cnt++;
      if (i == 3) S_ACK_I = 3'b010;
      tick();
    end
    S_ACK_I = '0;
    chk("write_stb_cycles", 128'(hi_cnt), 128'(4));
    chk("write_stb_clear", 128'(S_STB_O), 128'(3'b000));
    tick();
    M_CYC_I = 1'b0;
    tick();

    // Decode miss: error after one edge, no strobe.
    exp_q.push_back('{ack: 1'b0, err: 1'b1, dat: 32'hDEADBEEF});
    request(1'b0, 32'h8000_0000, 32'h0, 4'hF);
    chk("miss_err", 128'({S_STB_O, M_ACK_O, M_ERR_O}), 128'({3'b000, 2'b01}));
    tick();
    M_CYC_I = 1'b0;
    chk("miss_err_single", 128'({S_STB_O, M_ERR_O}), 128'(4'b0000));
    tick();

    // Slave 2 ACK+ERR together, after a spurious ACK from slave 0.
    exp_q.push_back('{ack: 1'b0, err: 1'b1, dat: 32'hDEADBEEF});
    S_DAT_I[31:0]  = 32'h0BAD_0BAD;
    S_DAT_I[95:64] = 32'h1234_5678;
    request(1'b0, 32'hFFFF_4004, 32'h0, 4'hF);
    chk("err_stb", 128'(S_STB_O), 128'(3'b100));
    S_ACK_I = 3'b001;
    tick();
    chk("spurious_ignored", 128'({S_STB_O, M_ACK_O, M_ERR_O}), 128'({3'b100, 2'b00}));
    S_ACK_I = 3'b101; S_ERR_I = 3'b100;
    tick();
    S_ACK_I = '0; S_ERR_I = '0;
    chk("err_wins", 128'({S_STB_O, M_ACK_O, M_ERR_O}), 128'({3'b000, 2'b01}));
    tick();
    M_CYC_I = 1'b0;
    tick();

    // Abort: CYC dropped in the second ACTIVE cycle.
    request(1'b0, 32'h0000_0020, 32'h0, 4'hF);
    tick();
    chk("abort_stb_held", 128'(S_STB_O), 128'(3'b001));
    M_CYC_I = 1'b0;
    tick();
    chk("abort_stb_clear", 128'({S_STB_O, M_ACK_O, M_ERR_O}), 128'(0));
    tick(); tick(); tick();

    // Asynchronous reset while ACTIVE.
    request(1'b1, 32'hFFFF_0000, 32'hCAFE_F00D, 4'h3);
    chk("pre_reset_stb", 128'(S_STB_O), 128'(3'b010));
    #2;
    I_rst = 1'b0;
    #1;
    chk("async_reset", 128'({M_DAT_O, M_ACK_O, M_ERR_O, S_STB_O, S_WE_O, S_ADR_O, S_DAT_O, S_SEL_O}), 128'(0));
    idle_bus();
    tick();
    I_rst = 1'b1;
    tick();

`ifdef WBIC_TIMEOUT_EN
    // Timeout: slave 0 silent, strobe held 8 cycles then ERR.
    exp_q.push_back('{ack: 1'b0, err: 1'b1, dat: 32'h0});
    request(1'b0, 32'h0000_0040, 32'h0, 4'hF);
    hi_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (S_STB_O == 3'b001) hi_cnt++;
      tick();
    end
    chk("timeout_stb_cycles", 128'(hi_cnt), 128'(8));
    chk("timeout_err", 128'({S_STB_O, M_ACK_O, M_ERR_O}), 128'({3'b000, 2'b01}));
    tick();
    M_CYC_I = 1'b0;
    tick();
`else
    // No timeout: strobe stays high until the master gives up.
    request(1'b0, 32'h0000_0040, 32'h0, 4'hF);
    hi_cnt = 0;
    for (int i = 0; i < 1010; i++) begin
      if (S_STB_O == 3'b001 && !M_ERR_O) hi_cnt++;
      tick();
    end
    chk("no_timeout_stb_cycles", 128'(hi_cnt), 128'(1010));
    M_CYC_I = 1'b0;
    tick();
    chk("no_timeout_abort", 128'({S_STB_O, M_ACK_O, M_ERR_O}), 128'(0));
    tick();
`endif

    tick(); tick();
    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
